// File: rtl/weight_load_ctrl_pkg.sv
// Shared constants and state encoding for the weight-load controller.
package wt_ctrl_pkg;

  localparam int unsigned WT_DW    = 8;
  localparam int unsigned WT_DEPTH = 16;
  localparam int unsigned WT_AW    = 12;

  typedef logic [1:0] wl_state_t;

  localparam wl_state_t WL_IDLE  = 2'd0;
  localparam wl_state_t WL_FETCH = 2'd1;
  localparam wl_state_t WL_DRAIN = 2'd2;
  localparam wl_state_t WL_READY = 2'd3;

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Scheduler command, SRAM read port and weight-RF shift signals of the load controller.
interface weight_load_ctrl_if
  import wt_ctrl_pkg::*;
#(
  parameter int unsigned AW = WT_AW,
  parameter int unsigned DW = WT_DW
) ();

  logic          cmd_valid;
  logic [AW-1:0] cmd_base;
  logic          cmd_ready;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic [DW-1:0] mem_rdata;
  logic          rf_wen;
  logic [DW-1:0] rf_din;
  logic          weights_valid;
  logic          compute_done;
  logic          busy;

  modport master (
    input  cmd_valid, cmd_base, mem_gnt, mem_rdata, compute_done,
    output cmd_ready, mem_req, mem_addr, rf_wen, rf_din, weights_valid, busy
  );

  modport slave (
    output cmd_valid, cmd_base, mem_gnt, mem_rdata, compute_done,
    input  cmd_ready, mem_req, mem_addr, rf_wen, rf_din, weights_valid, busy
  );

endinterface

// File: rtl/weight_load_ctrl.sv
// Fetches DEPTH consecutive weights from the shared SRAM and shifts them into the PE weight RF,
// then holds weights_valid until the PE array reports compute_done.
module weight_load_ctrl
  import wt_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WT_DEPTH,
  parameter int unsigned AW    = WT_AW,
  parameter int unsigned DW    = WT_DW
) (
  input logic                clk,
  input logic                rst,
  weight_load_ctrl_if.master bus
);

  localparam int unsigned    CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

  wl_state_t     state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rvalid_q;
  logic          issue;

  assign issue = (state_q == WL_FETCH) && bus.mem_gnt;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    if (rvalid_q) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    case (state_q)
      WL_IDLE: begin
        if (bus.cmd_valid) begin
          base_d      = bus.cmd_base;
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          state_d     = WL_FETCH;
        end
      end
      WL_FETCH: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST) begin
            state_d = WL_DRAIN;
          end
        end
      end
      WL_DRAIN: begin
        // The write landing this cycle is the last one; the set is complete next cycle.
        if (rvalid_q && (wr_cnt_q == LAST)) begin
          state_d = WL_READY;
        end
      end
      WL_READY: begin
        if (bus.compute_done) begin
          state_d = WL_IDLE;
        end
      end
      default: state_d = WL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WL_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rvalid_q    <= issue;
    end
  end

  assign bus.cmd_ready     = (state_q == WL_IDLE);
  assign bus.mem_req       = (state_q == WL_FETCH);
  // Address arithmetic truncates to AW bits, so a load may wrap past the top of the SRAM.
  assign bus.mem_addr      = bus.mem_req ? (base_q + AW'(issue_cnt_q)) : '0;
  assign bus.rf_wen        = rvalid_q;
  assign bus.rf_din        = rvalid_q ? bus.mem_rdata : '0;
  assign bus.weights_valid = (state_q == WL_READY);
  assign bus.busy          = (state_q != WL_IDLE);

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Randomised scoreboard bench for weight_load_ctrl with an SRAM model and a weight RF model.
module tb_weight_load_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_load_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  weight_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] sram [4096];
  int            gnt_mode = 0;
  logic          tog = 1'b1;
  logic          pend_issue = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] addr_q [$];
  logic [DW-1:0] rf_model [DEPTH];
  int            load_wr = 0;
  int            first_wr = 0;
  int            last_wr = 0;
  int            rise_cyc = 0;
  logic          prev_wv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM + arbiter model: data for a read granted at a posedge appears in the following cycle.
  always @(negedge clk) begin
    bus.mem_rdata = pend_issue ? sram[pend_addr] : DW'($urandom);
    case (gnt_mode)
      0:       bus.mem_gnt = 1'b1;
      1:       begin bus.mem_gnt = tog; tog = ~tog; end
      default: bus.mem_gnt = 1'($urandom_range(0, 1));
    endcase
    #1;
    pend_issue = bus.mem_req & bus.mem_gnt;
    pend_addr  = bus.mem_addr;
  end

  // Monitor: checks addresses and RF writes against the scoreboard queues.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    #2;
    if (!rst) begin
      if (bus.mem_req) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_addr: got 0x%0h expected no request", bus.mem_addr);
        end else begin
          chk("mem_addr", 32'(bus.mem_addr), 32'(addr_q[0]));
          if (bus.mem_gnt) void'(addr_q.pop_front());
        end
      end
      if (bus.rf_wen) begin
        chk("wen_in_load", 32'(bus.busy && !bus.weights_valid), 32'd1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rf_din: got 0x%0h expected no write", bus.rf_din);
        end else begin
          e = exp_q.pop_front();
          chk("rf_din", 32'(bus.rf_din), 32'(e));
        end
        for (int i = 0; i < DEPTH - 1; i++) rf_model[i] = rf_model[i+1];
        rf_model[DEPTH-1] = bus.rf_din;
        load_wr++;
        if (load_wr == 1) first_wr = cyc;
        last_wr = cyc;
      end else begin
        chk("rf_din_idle", 32'(bus.rf_din), 32'd0);
      end
      if (bus.weights_valid && !prev_wv) begin
        rise_cyc = cyc;
        chk("wr_count", 32'(load_wr), 32'(DEPTH));
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      end
    end
    prev_wv = bus.weights_valid;
  end

  task automatic push_expected(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      a = base + AW'(i);
      exp_q.push_back(sram[a]);
      addr_q.push_back(a);
    end
    load_wr = 0;
  endtask

  task automatic start_load(input logic [AW-1:0] base, output int c0);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    c0 = cyc;
    push_expected(base);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.weights_valid && n < 300) begin @(negedge clk); n++; end
    chk("wv_timeout", 32'(bus.weights_valid), 32'd1);
    #3;
  endtask

  task automatic check_rf(input logic [AW-1:0] base);
    int mism = 0;
    logic [AW-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      a = base + AW'(i);
      if (rf_model[i] !== sram[a]) mism++;
    end
    chk("rf_contents_mismatches", 32'(mism), 32'd0);
  endtask

  task automatic finish_compute();
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    chk("wv_drop", 32'(bus.weights_valid), 32'd0);
    chk("cmd_ready_after_done", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_rf_wen"}, 32'(bus.rf_wen), 32'd0);
    chk({tag, "_rf_din"}, 32'(bus.rf_din), 32'd0);
    chk({tag, "_weights_valid"}, 32'(bus.weights_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int c0;
    int n;
    logic [AW-1:0] b;
    rst = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_base     = '0;
    bus.compute_done = 1'b0;
    bus.mem_gnt      = 1'b1;
    bus.mem_rdata    = '0;
    for (int i = 0; i < 4096; i++) sram[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: continuous grant, known data, exact latency
    gnt_mode = 0;
    for (int i = 0; i < DEPTH; i++) sram[12'h010 + i] = DW'(i + 1);
    start_load(12'h010, c0);
    wait_valid();
    chk("first_write_cycle", 32'(first_wr - c0), 32'd2);
    chk("last_write_cycle", 32'(last_wr - c0), 32'd17);
    chk("wv_rise_cycle", 32'(rise_cyc - c0), 32'd18);
    check_rf(12'h010);
    chk("rf_entry15", 32'(rf_model[15]), 32'd16);
    finish_compute();

    // 2: alternating grant
    gnt_mode = 1;
    b = AW'($urandom);
    start_load(b, c0);
    wait_valid();
    check_rf(b);
    finish_compute();

    // 3: address wrap
    gnt_mode = 0;
    start_load(12'hFFA, c0);
    wait_valid();
    check_rf(12'hFFA);
    chk("rf_entry6_wrap", 32'(rf_model[6]), 32'(sram[0]));
    finish_compute();

    // 4: commands while busy are ignored; cmd with compute_done in READY is taken next cycle
    gnt_mode = 2;
    b = AW'($urandom);
    start_load(b, c0);
    repeat (3) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_base  = AW'($urandom);
      chk("cmd_ready_fetch", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    wait_valid();
    check_rf(b);
    b = AW'($urandom);
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = b;
    chk("cmd_ready_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("wv_hold_with_cmd", 32'(bus.weights_valid), 32'd1);
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    chk("wv_drop_cmd", 32'(bus.weights_valid), 32'd0);
    chk("cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
    push_expected(b);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_valid();
    check_rf(b);
    finish_compute();

    // 5: reset during the 8th write, then a clean load
    gnt_mode = 0;
    start_load(AW'($urandom), c0);
    n = 0;
    while (load_wr != 7 && n < 100) begin @(negedge clk); n++; end
    chk("reach_7_writes", 32'(load_wr), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midload_rst");
    exp_q.delete();
    addr_q.delete();
    load_wr = 0;
    rst = 1'b0;
    b = AW'($urandom);
    start_load(b, c0);
    wait_valid();
    check_rf(b);
    finish_compute();

    // 6: compute_done outside READY has no effect
    gnt_mode = 2;
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    chk("idle_done_ignored", 32'(bus.cmd_ready), 32'd1);
    b = AW'($urandom);
    start_load(b, c0);
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    chk("fetch_done_ignored", 32'(bus.busy && !bus.weights_valid), 32'd1);
    wait_valid();
    check_rf(b);
    finish_compute();

    // Random loads with random grant
    repeat (4) begin
      b = AW'($urandom);
      start_load(b, c0);
      wait_valid();
      check_rf(b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("wv_held", 32'(bus.weights_valid), 32'd1);
      finish_compute();
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
